// File: rtl/mips32_pkg.sv
// Shared pipeline definitions: word width, opcode/type constants, reset PC
// and the prefetch FSM state encoding.
package mips32_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    // Primary opcode field values decoded further down the pipeline.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    typedef enum logic [2:0] {
        TYPE_RR     = 3'd0,
        TYPE_RM     = 3'd1,
        TYPE_LOAD   = 3'd2,
        TYPE_STORE  = 3'd3,
        TYPE_BRANCH = 3'd4,
        TYPE_HALT   = 3'd5
    } instr_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } pf_state_e;

    function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] addr);
        return addr + 32'd1;
    endfunction

endpackage

// File: rtl/mips32_prefetch_queue_if.sv
// Bundle of the instruction-memory bus, the IF-stage handshake and the
// branch/halt controls seen by the prefetch queue.
interface mips32_prefetch_queue_if
    import mips32_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              mem_req;
    logic [WORD_W-1:0] mem_addr;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;
    logic              instr_valid;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] instr_npc;
    logic              instr_ready;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic              halt;
    logic [CW-1:0]     count;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_npc, count,
        input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_npc, count,
        output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc, halt
    );

endinterface

// File: rtl/mips32_sync_fifo.sv
// Synchronous FIFO with flush; the head entry is held in its own register so
// the consumer never sees a combinational path from push_data.
module mips32_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] STEP_C  = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r, wr_ptr_r;
    logic [CW-1:0]    count_r, count_nxt_s;
    logic [WIDTH-1:0] head_r, head_nxt_s;
    logic             valid_r;
    logic             push_ok_s, pop_ok_s;

    // Qualify requests and work out occupancy and head entry after this edge.
    always_comb begin
        push_ok_s  = push & (count_r != DEPTH_C);
        pop_ok_s   = pop & (count_r != ZERO_C);
        head_nxt_s = head_r;
        if (flush) begin
            count_nxt_s = ZERO_C;
        end else begin
            count_nxt_s = count_r + {{(CW-1){1'b0}}, push_ok_s} - {{(CW-1){1'b0}}, pop_ok_s};
        end
        if (flush) begin
            head_nxt_s = head_r;
        end else if (pop_ok_s && (count_r == ONE_C)) begin
            head_nxt_s = push_ok_s ? push_data : head_r;
        end else if (pop_ok_s) begin
            head_nxt_s = mem_r[rd_ptr_r + STEP_C];
        end else if (push_ok_s && (count_r == ZERO_C)) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= ZERO_C;
            head_r   <= {WIDTH{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            head_r  <= head_nxt_s;
            valid_r <= (count_nxt_s != ZERO_C);
            if (flush) begin
                rd_ptr_r <= {AW{1'b0}};
                wr_ptr_r <= {AW{1'b0}};
            end else begin
                if (push_ok_s) wr_ptr_r <= wr_ptr_r + STEP_C;
                if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + STEP_C;
            end
        end
    end

    // Entry storage; contents are only read once written.
    always_ff @(posedge clk1) begin
        if (push_ok_s && !flush) mem_r[wr_ptr_r] <= push_data;
    end

    assign head_valid = valid_r;
    assign head_data  = head_r;
    assign count      = count_r;

endmodule

// File: rtl/mips32_prefetch_queue.sv
// Instruction prefetch queue: one outstanding word fetch at a time into a
// small FIFO feeding IF, with branch redirect flush and sticky halt.
module mips32_prefetch_queue
    import mips32_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                    clk1,
    input  logic                    rst_n,
    mips32_prefetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    pf_state_e         state_r, state_nxt_s;
    logic [WORD_W-1:0] fetch_pc_r, fetch_pc_nxt_s;
    logic [WORD_W-1:0] mem_addr_r, mem_addr_nxt_s;
    logic              mem_req_r, mem_req_nxt_s;
    logic              halted_r, halt_eff_s;
    logic              issue_s, push_s, pop_s;
    logic [CW-1:0]     count_s;
    logic              head_valid_s;
    logic [63:0]       head_data_s;

    assign halt_eff_s = bus.halt | halted_r;

    // State register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a halt seen at any point lands in HALTED once no fetch is pending.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (halt_eff_s)              state_nxt_s = ST_HALTED;
                else if (bus.redirect)       state_nxt_s = ST_IDLE;
                else if (count_s != DEPTH_C) state_nxt_s = ST_WAIT;
                else                         state_nxt_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (bus.mem_ack)       state_nxt_s = halt_eff_s ? ST_HALTED : ST_IDLE;
                else if (bus.redirect) state_nxt_s = ST_DRAIN;
                else                   state_nxt_s = ST_WAIT;
            end
            ST_DRAIN: begin
                if (bus.mem_ack) state_nxt_s = halt_eff_s ? ST_HALTED : ST_IDLE;
                else             state_nxt_s = ST_DRAIN;
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/datapath decode: issue, push, PC and bus register next values.
    always_comb begin
        issue_s = (state_r == ST_IDLE) && (state_nxt_s == ST_WAIT);
        push_s  = (state_r == ST_WAIT) && bus.mem_ack && !bus.redirect;
        pop_s   = head_valid_s & bus.instr_ready;
        if (issue_s) begin
            mem_req_nxt_s = 1'b1;
        end else if (((state_r == ST_WAIT) || (state_r == ST_DRAIN)) && bus.mem_ack) begin
            mem_req_nxt_s = 1'b0;
        end else begin
            mem_req_nxt_s = mem_req_r;
        end
        if (issue_s) begin
            mem_addr_nxt_s = fetch_pc_r;
        end else begin
            mem_addr_nxt_s = mem_addr_r;
        end
        if (bus.redirect) begin
            fetch_pc_nxt_s = bus.redirect_pc;
        end else if (push_s) begin
            fetch_pc_nxt_s = next_word(fetch_pc_r);
        end else begin
            fetch_pc_nxt_s = fetch_pc_r;
        end
    end

    // Fetch PC, memory bus registers and sticky halt flag.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 32'h0000_0000;
            halted_r   <= 1'b0;
        end else begin
            fetch_pc_r <= fetch_pc_nxt_s;
            mem_req_r  <= mem_req_nxt_s;
            mem_addr_r <= mem_addr_nxt_s;
            halted_r   <= halted_r | bus.halt;
        end
    end

    mips32_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_data  ({bus.mem_rdata, next_word(fetch_pc_r)}),
        .pop        (pop_s),
        .flush      (bus.redirect),
        .head_valid (head_valid_s),
        .head_data  (head_data_s),
        .count      (count_s)
    );

    assign bus.mem_req     = mem_req_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.instr_valid = head_valid_s;
    assign bus.instr       = head_data_s[63:32];
    assign bus.instr_npc   = head_data_s[31:0];
    assign bus.count       = count_s;

endmodule

// File: tb/tb_mips32_prefetch_queue.sv
// Directed scenarios followed by a randomized run checked against a
// transaction-level queue model of the prefetcher.
module tb_mips32_prefetch_queue;
    import mips32_pkg::*;

    localparam int DEPTH = 4;

    logic clk1  = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [63:0] mq [$];
    logic [31:0] m_pc;
    bit          m_drain;
    bit          rdy, ack, rd;
    logic [31:0] rpc;

    mips32_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

    mips32_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.mem_ack = 1'b0; bus.redirect = 1'b0; bus.halt = 1'b0; bus.instr_ready = 1'b0;
        @(negedge clk1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req",   32'(bus.mem_req), 32'd0);
        chk("rst_addr",  bus.mem_addr, 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_npc",   bus.instr_npc, 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        @(negedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);
        chk("first_req",  32'(bus.mem_req), 32'd1);
        chk("first_addr", bus.mem_addr, 32'd0);
    endtask

    task automatic wait_req(input logic [31:0] exp, input string tag);
        for (int i = 0; i < 20 && bus.mem_req !== 1'b1; i++) @(negedge clk1);
        chk({tag, "_req"},  32'(bus.mem_req), 32'd1);
        chk({tag, "_addr"}, bus.mem_addr, exp);
    endtask

    task automatic ack_now();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mdata(bus.mem_addr);
        @(negedge clk1);
        bus.mem_ack   = 1'b0;
    endtask

    task automatic serve(input logic [31:0] exp, input int lat, input string tag);
        wait_req(exp, tag);
        repeat (lat) @(negedge clk1);
        ack_now();
    endtask

    task automatic expect_head(input logic [31:0] a, input string tag);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, "_instr"}, bus.instr, mdata(a));
        chk({tag, "_npc"},   bus.instr_npc, a + 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0; bus.instr_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = 32'd0; bus.halt = 1'b0;

        // Sequential fetch, one-cycle memory latency, consumer always ready.
        do_reset();
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            serve(32'(k), 1, "seq");
            expect_head(32'(k), "seq_head");
        end

        // Back-pressure: FIFO fills, then one pop allows exactly one refetch.
        do_reset();
        for (int k = 0; k < 4; k++) serve(32'(k), 0, "fill");
        chk("full_count", 32'(bus.count), 32'd4);
        repeat (4) begin
            @(negedge clk1);
            chk("full_noreq", 32'(bus.mem_req), 32'd0);
            chk("full_hold",  32'(bus.count), 32'd4);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk1);
        bus.instr_ready = 1'b0;
        chk("pop1_count", 32'(bus.count), 32'd3);
        expect_head(32'd1, "pop1_head");
        serve(32'd4, 0, "refill");
        chk("refill_count", 32'(bus.count), 32'd4);
        repeat (4) begin
            @(negedge clk1);
            chk("refill_noreq", 32'(bus.mem_req), 32'd0);
        end

        // Redirect while waiting on addr 5; late ack is dropped.
        do_reset();
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) serve(32'(k), 1, "pre");
        wait_req(32'd5, "w5");
        bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
        @(negedge clk1);
        bus.redirect = 1'b0;
        chk("drain_count", 32'(bus.count), 32'd0);
        chk("drain_req",   32'(bus.mem_req), 32'd1);
        chk("drain_addr",  bus.mem_addr, 32'd5);
        @(negedge clk1);
        @(negedge clk1);
        ack_now();
        chk("drop_count", 32'(bus.count), 32'd0);
        chk("drop_valid", 32'(bus.instr_valid), 32'd0);
        serve(32'h40, 1, "rd40");
        expect_head(32'h40, "rd40_head");

        // Redirect coincident with ack and pop.
        do_reset();
        serve(32'd0, 1, "c0");
        expect_head(32'd0, "c0_head");
        wait_req(32'd1, "c1");
        bus.mem_ack = 1'b1; bus.mem_rdata = mdata(32'd1);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h100; bus.instr_ready = 1'b1;
        @(negedge clk1);
        bus.mem_ack = 1'b0; bus.redirect = 1'b0; bus.instr_ready = 1'b0;
        chk("coinc_count", 32'(bus.count), 32'd0);
        chk("coinc_valid", 32'(bus.instr_valid), 32'd0);
        chk("coinc_req",   32'(bus.mem_req), 32'd0);
        serve(32'h100, 1, "r100");
        expect_head(32'h100, "r100_head");
        chk("r100_count", 32'(bus.count), 32'd1);

        // Halt while waiting on addr 7: word 7 lands, then nothing more.
        do_reset();
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 7; k++) serve(32'(k), 1, "h");
        wait_req(32'd7, "w7");
        bus.halt = 1'b1;
        @(negedge clk1);
        bus.halt = 1'b0;
        chk("halt_pend_req", 32'(bus.mem_req), 32'd1);
        bus.instr_ready = 1'b0;
        ack_now();
        expect_head(32'd7, "halt_head");
        chk("halt_count", 32'(bus.count), 32'd1);
        chk("halt_req0",  32'(bus.mem_req), 32'd0);
        repeat (5) begin
            @(negedge clk1);
            chk("halt_noreq", 32'(bus.mem_req), 32'd0);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk1);
        bus.instr_ready = 1'b0;
        chk("halt_drained", 32'(bus.count), 32'd0);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
        @(negedge clk1);
        bus.redirect = 1'b0;
        repeat (5) begin
            @(negedge clk1);
            chk("halted_rd_noreq", 32'(bus.mem_req), 32'd0);
        end

        // Halt and redirect together while waiting.
        do_reset();
        bus.halt = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h80;
        @(negedge clk1);
        bus.halt = 1'b0; bus.redirect = 1'b0;
        chk("hr_pend_req", 32'(bus.mem_req), 32'd1);
        ack_now();
        chk("hr_count", 32'(bus.count), 32'd0);
        repeat (4) begin
            @(negedge clk1);
            chk("hr_noreq", 32'(bus.mem_req), 32'd0);
        end

        // Address wrap at the top of the word space.
        do_reset();
        bus.instr_ready = 1'b1;
        bus.mem_ack = 1'b1; bus.mem_rdata = mdata(32'd0);
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk1);
        bus.mem_ack = 1'b0; bus.redirect = 1'b0;
        chk("wrap_flush", 32'(bus.count), 32'd0);
        serve(32'hFFFF_FFFF, 1, "wrapF");
        expect_head(32'hFFFF_FFFF, "wrapF_head");
        chk("wrap_npc0", bus.instr_npc, 32'h0000_0000);
        serve(32'd0, 1, "wrap0");
        expect_head(32'd0, "wrap0_head");

        // Randomized traffic against a transaction-level queue model.
        do_reset();
        mq.delete();
        m_pc = 32'd0;
        m_drain = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            chk("r_count", 32'(bus.count), 32'(mq.size()));
            chk("r_valid", 32'(bus.instr_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("r_instr", bus.instr, mq[0][63:32]);
                chk("r_npc",   bus.instr_npc, mq[0][31:0]);
            end
            if (bus.mem_req && !m_drain) chk("r_addr", bus.mem_addr, m_pc);
            rdy = ($urandom_range(0, 3) != 0);
            ack = bus.mem_req && ($urandom_range(0, 2) == 0);
            rd  = ($urandom_range(0, 24) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            bus.instr_ready = rdy;
            bus.mem_ack     = ack;
            bus.mem_rdata   = ack ? mdata(bus.mem_addr) : $urandom;
            bus.redirect    = rd;
            bus.redirect_pc = rpc;
            if (rd) begin
                mq.delete();
                m_drain = bus.mem_req && !ack;
                m_pc = rpc;
            end else begin
                if (rdy && mq.size() != 0) void'(mq.pop_front());
                if (ack) begin
                    if (!m_drain) begin
                        mq.push_back({mdata(m_pc), m_pc + 32'd1});
                        m_pc = m_pc + 32'd1;
                    end
                    m_drain = 1'b0;
                end
            end
            @(negedge clk1);
        end
        bus.mem_ack = 1'b0; bus.redirect = 1'b0; bus.instr_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
